// File: rtl/branch_unit_pkg.sv
// Shared definitions for the branch resolution unit.
//   comp_ctrl_e : branch compare selector (RV32I funct3 encoding)
//   pcsrc_e     : next-PC source selector driven to fetch
//   SNT..ST     : 2-bit bimodal counter states
package branch_unit_pkg;

  typedef enum logic [2:0] {
    COMP_EQ  = 3'b000,
    COMP_NE  = 3'b001,
    COMP_LT  = 3'b100,
    COMP_GE  = 3'b101,
    COMP_LTU = 3'b110,
    COMP_GEU = 3'b111
  } comp_ctrl_e;

  typedef enum logic [1:0] {
    PCSRC_SEQ  = 2'b00,
    PCSRC_REL  = 2'b01,
    PCSRC_JALR = 2'b10
  } pcsrc_e;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

endpackage

// File: rtl/bimodal_pred.sv
// Bimodal direction predictor: DEPTH saturating 2-bit counters.
//   clk, reset : clock, async active-high reset (all entries -> WNT)
//   rd_pc      : fetch PC; rd_taken is the MSB of its entry (combinational,
//                no bypass from a same-cycle write)
//   wr_en, wr_idx, wr_taken : train one entry toward taken / not-taken
module bimodal_pred
  import branch_unit_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int N     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N-1:0]             rd_pc,
  output logic                     rd_taken,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic                     wr_taken
);

  localparam int IW = $clog2(DEPTH);

  logic [1:0] tbl [DEPTH];
  logic       unused_pc_bits;

  // Only the word-index bits of the fetch PC select an entry.
  assign unused_pc_bits = ^{rd_pc[N-1:IW+2], rd_pc[1:0]};
  assign rd_taken = tbl[rd_pc[IW+1:2]][1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= WNT;
    end else if (wr_en) begin
      if (wr_taken) begin
        if (tbl[wr_idx] != ST) tbl[wr_idx] <= tbl[wr_idx] + 2'b01;
      end else begin
        if (tbl[wr_idx] != SNT) tbl[wr_idx] <= tbl[wr_idx] - 2'b01;
      end
    end
  end

endmodule

// File: rtl/branch_unit.sv
// Registered branch resolution unit for the RV32I execute stage.
// Resolves Branch/JAL/JALR, computes target and link, flags mispredicts,
// trains the bimodal predictor and keeps saturating perf counters.
//   inputs : valid_i/stall_i/flush_i handshake, pc_i, a_i, b_i, imm_i,
//            comp_ctrl_i, Branch_i/Jump_i/Jalr_i, pred_taken_i, fetch_pc_i
//   outputs: fetch_pred_taken_o (combinational), registered res_valid_o,
//            PCSrc_o, taken_o, mispredict_o, redirect_pc_o, link_o,
//            br_cnt_o, mp_cnt_o
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [N-1:0]     pc_i,
  input  logic [N-1:0]     a_i,
  input  logic [N-1:0]     b_i,
  input  logic [N-1:0]     imm_i,
  input  logic [2:0]       comp_ctrl_i,
  input  logic             Branch_i,
  input  logic             Jump_i,
  input  logic             Jalr_i,
  input  logic             pred_taken_i,
  input  logic [N-1:0]     fetch_pc_i,
  output logic             fetch_pred_taken_o,
  output logic             res_valid_o,
  output logic [1:0]       PCSrc_o,
  output logic             taken_o,
  output logic             mispredict_o,
  output logic [N-1:0]     redirect_pc_o,
  output logic [N-1:0]     link_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] mp_cnt_o
);

  localparam int IW = $clog2(DEPTH);

  logic         acc, is_jump, is_jalr, is_br, cond, taken_c, mp_c;
  logic [N-1:0] rel_tgt, jalr_sum, link_c, target_c;
  pcsrc_e       pcsrc_c;

  assign acc      = valid_i & ~stall_i & ~flush_i;
  // Jump > Jalr > Branch when decode asserts more than one.
  assign is_jump  = Jump_i;
  assign is_jalr  = Jalr_i & ~Jump_i;
  assign is_br    = Branch_i & ~Jump_i & ~Jalr_i;
  assign rel_tgt  = pc_i + imm_i;
  assign jalr_sum = a_i + imm_i;
  assign link_c   = pc_i + N'(4);

  always_comb begin
    cond = 1'b0;
    case (comp_ctrl_e'(comp_ctrl_i))
      COMP_EQ:  cond = (a_i == b_i);
      COMP_NE:  cond = (a_i != b_i);
      COMP_LT:  cond = ($signed(a_i) <  $signed(b_i));
      COMP_GE:  cond = ($signed(a_i) >= $signed(b_i));
      COMP_LTU: cond = (a_i <  b_i);
      COMP_GEU: cond = (a_i >= b_i);
      default:  cond = 1'b0;
    endcase
  end

  always_comb begin
    taken_c  = 1'b0;
    target_c = rel_tgt;
    pcsrc_c  = PCSRC_SEQ;
    mp_c     = 1'b0;
    if (is_jump) begin
      taken_c = 1'b1;
      pcsrc_c = PCSRC_REL;
      mp_c    = 1'b1;
    end else if (is_jalr) begin
      taken_c  = 1'b1;
      target_c = {jalr_sum[N-1:1], 1'b0};
      pcsrc_c  = PCSRC_JALR;
      mp_c     = 1'b1;
    end else if (is_br) begin
      taken_c = cond;
      pcsrc_c = cond ? PCSRC_REL : PCSRC_SEQ;
      mp_c    = (cond != pred_taken_i);
    end
  end

  bimodal_pred #(.DEPTH(DEPTH), .N(N)) u_pred (
    .clk      (clk),
    .reset    (reset),
    .rd_pc    (fetch_pc_i),
    .rd_taken (fetch_pred_taken_o),
    .wr_en    (acc & is_br),
    .wr_idx   (pc_i[IW+1:2]),
    .wr_taken (cond)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid_o   <= 1'b0;
      PCSrc_o       <= PCSRC_SEQ;
      taken_o       <= 1'b0;
      mispredict_o  <= 1'b0;
      redirect_pc_o <= '0;
      link_o        <= '0;
      br_cnt_o      <= '0;
      mp_cnt_o      <= '0;
    end else if (flush_i || (!stall_i && !valid_i)) begin
      res_valid_o  <= 1'b0;
      mispredict_o <= 1'b0;
      PCSrc_o      <= PCSRC_SEQ;
    end else if (acc) begin
      res_valid_o   <= 1'b1;
      PCSrc_o       <= pcsrc_c;
      taken_o       <= taken_c;
      mispredict_o  <= mp_c;
      redirect_pc_o <= taken_c ? target_c : link_c;
      link_o        <= link_c;
      if (is_br && br_cnt_o != '1) br_cnt_o <= br_cnt_o + 1'b1;
      if (mp_c && mp_cnt_o != '1) mp_cnt_o <= mp_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: default instance plus a CNT_W=2 instance
// driven by the same stimulus to exercise counter saturation.
module tb_branch_unit;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_i, stall_i, flush_i;
  logic [N-1:0]  pc_i, a_i, b_i, imm_i, fetch_pc_i;
  logic [2:0]    comp_ctrl_i;
  logic          Branch_i, Jump_i, Jalr_i, pred_taken_i;
  logic          fetch_pred_taken_o, res_valid_o, taken_o, mispredict_o;
  logic [1:0]    PCSrc_o;
  logic [N-1:0]  redirect_pc_o, link_o;
  logic [15:0]   br_cnt_o, mp_cnt_o;

  logic          fp2, rv2, tk2, mp2;
  logic [1:0]    ps2;
  logic [N-1:0]  rd2, lk2;
  logic [1:0]    br2, mc2;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  branch_unit dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .pc_i(pc_i), .a_i(a_i), .b_i(b_i), .imm_i(imm_i), .comp_ctrl_i(comp_ctrl_i),
    .Branch_i(Branch_i), .Jump_i(Jump_i), .Jalr_i(Jalr_i), .pred_taken_i(pred_taken_i),
    .fetch_pc_i(fetch_pc_i), .fetch_pred_taken_o(fetch_pred_taken_o),
    .res_valid_o(res_valid_o), .PCSrc_o(PCSrc_o), .taken_o(taken_o),
    .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o), .link_o(link_o),
    .br_cnt_o(br_cnt_o), .mp_cnt_o(mp_cnt_o)
  );

  branch_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .pc_i(pc_i), .a_i(a_i), .b_i(b_i), .imm_i(imm_i), .comp_ctrl_i(comp_ctrl_i),
    .Branch_i(Branch_i), .Jump_i(Jump_i), .Jalr_i(Jalr_i), .pred_taken_i(pred_taken_i),
    .fetch_pc_i(fetch_pc_i), .fetch_pred_taken_o(fp2),
    .res_valid_o(rv2), .PCSrc_o(ps2), .taken_o(tk2),
    .mispredict_o(mp2), .redirect_pc_o(rd2), .link_o(lk2),
    .br_cnt_o(br2), .mp_cnt_o(mc2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_i = 0; stall_i = 0; flush_i = 0;
    Branch_i = 0; Jump_i = 0; Jalr_i = 0; pred_taken_i = 0;
    pc_i = '0; a_i = '0; b_i = '0; imm_i = '0; comp_ctrl_i = 3'b000;
  endtask

  task automatic br(input logic [2:0] cc, input logic [N-1:0] a, input logic [N-1:0] b,
                    input logic [N-1:0] pc, input logic [N-1:0] imm, input logic pred);
    idle();
    valid_i = 1; Branch_i = 1; comp_ctrl_i = cc;
    a_i = a; b_i = b; pc_i = pc; imm_i = imm; pred_taken_i = pred;
  endtask

  initial begin
    idle();
    fetch_pc_i = 32'h40;
    reset = 1;
    step(); step();
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_redirect", redirect_pc_o, 0);
    chk("rst_br_cnt", br_cnt_o, 0);
    chk("rst_fetch_pred", fetch_pred_taken_o, 0);
    reset = 0;
    step();

    // BLT signed: -1 < 1
    br(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 0);
    step();
    chk("blt_valid", res_valid_o, 1);
    chk("blt_taken", taken_o, 1);
    chk("blt_pcsrc", PCSrc_o, 2'b01);
    chk("blt_redirect", redirect_pc_o, 32'h120);
    chk("blt_link", link_o, 32'h104);
    chk("blt_mp", mispredict_o, 1);
    chk("blt_mp_cnt", mp_cnt_o, 1);
    chk("blt_br_cnt", br_cnt_o, 1);
    chk("blt_br2", br2, 1);

    // BLTU: 0xFFFFFFFF < 1 is false
    br(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 0);
    step();
    chk("bltu_taken", taken_o, 0);
    chk("bltu_pcsrc", PCSrc_o, 2'b00);
    chk("bltu_redirect", redirect_pc_o, 32'h104);
    chk("bltu_mp", mispredict_o, 0);
    chk("bltu_br_cnt", br_cnt_o, 2);

    // JALR: (0x1003 + 4) & ~1
    idle();
    valid_i = 1; Jalr_i = 1; a_i = 32'h1003; imm_i = 32'h4; pc_i = 32'h200;
    step();
    chk("jalr_redirect", redirect_pc_o, 32'h1006);
    chk("jalr_pcsrc", PCSrc_o, 2'b10);
    chk("jalr_link", link_o, 32'h204);
    chk("jalr_mp", mispredict_o, 1);
    chk("jalr_br_cnt", br_cnt_o, 2);
    chk("jalr_mp_cnt", mp_cnt_o, 2);

    idle();
    step();
    chk("idle_valid", res_valid_o, 0);
    chk("idle_mp", mispredict_o, 0);
    chk("idle_pcsrc", PCSrc_o, 2'b00);
    chk("train_pred0", fetch_pred_taken_o, 0);

    // Training index 16 (pc 0x40)
    br(3'b000, 32'h5, 32'h5, 32'h40, 32'h10, 0);
    #1;
    chk("train_no_bypass", fetch_pred_taken_o, 0);
    step();
    chk("train_pred1", fetch_pred_taken_o, 1);
    chk("beq_mp", mispredict_o, 1);
    chk("beq_br2", br2, 3);
    for (int i = 0; i < 3; i++) begin
      br(3'b000, 32'h5, 32'h5, 32'h40, 32'h10, 1);
      step();
      chk("beq_pred_hit_mp", mispredict_o, 0);
    end
    chk("br2_saturated", br2, 3);
    chk("br_cnt_6", br_cnt_o, 6);
    // BNE with equal operands: not taken, entry 11 -> 10
    br(3'b001, 32'h5, 32'h5, 32'h40, 32'h10, 1);
    step();
    chk("bne_taken", taken_o, 0);
    chk("bne_mp", mispredict_o, 1);
    chk("bne_mp_cnt", mp_cnt_o, 4);
    chk("mp2_saturated", mc2, 3);
    idle();
    chk("train_pred_weak", fetch_pred_taken_o, 1);
    fetch_pc_i = 32'h140;
    #1;
    chk("alias_pred", fetch_pred_taken_o, 1);
    fetch_pc_i = 32'h44;
    #1;
    chk("neighbour_pred", fetch_pred_taken_o, 0);
    fetch_pc_i = 32'h40;

    // BGE signed: -1 >= 1 false
    br(3'b101, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h20, 1);
    step();
    chk("bge_taken", taken_o, 0);
    chk("bge_redirect", redirect_pc_o, 32'h304);
    chk("bge_mp", mispredict_o, 1);
    // BGEU: 0xFFFFFFFF >= 1 true
    br(3'b111, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h20, 0);
    step();
    chk("bgeu_taken", taken_o, 1);
    chk("bgeu_redirect", redirect_pc_o, 32'h320);
    chk("bgeu_mp_cnt", mp_cnt_o, 6);
    // Undefined compare code: cond = 0
    br(3'b010, 32'h7, 32'h7, 32'h300, 32'h20, 0);
    step();
    chk("undef_taken", taken_o, 0);
    chk("undef_redirect", redirect_pc_o, 32'h304);
    chk("undef_br_cnt", br_cnt_o, 10);

    // Stall: JAL presented but held off for 3 cycles
    idle();
    valid_i = 1; stall_i = 1; Jump_i = 1; pc_i = 32'h500; imm_i = 32'h40;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", res_valid_o, 1);
      chk("stall_redirect", redirect_pc_o, 32'h304);
      chk("stall_taken", taken_o, 0);
      chk("stall_br_cnt", br_cnt_o, 10);
      chk("stall_mp_cnt", mp_cnt_o, 6);
    end

    // Flush beats stall; a not-taken BNE at 0x40 must not train
    br(3'b001, 32'h5, 32'h5, 32'h40, 32'h10, 1);
    stall_i = 1; flush_i = 1;
    step();
    chk("flush_valid", res_valid_o, 0);
    chk("flush_mp", mispredict_o, 0);
    chk("flush_pcsrc", PCSrc_o, 2'b00);
    chk("flush_br_cnt", br_cnt_o, 10);
    chk("flush_table", fetch_pred_taken_o, 1);

    // Reset in the cycle after acceptance
    br(3'b000, 32'h5, 32'h5, 32'h40, 32'h10, 1);
    step();
    chk("pre_reset_valid", res_valid_o, 1);
    reset = 1;
    #1;
    chk("ar_valid", res_valid_o, 0);
    chk("ar_taken", taken_o, 0);
    chk("ar_redirect", redirect_pc_o, 0);
    chk("ar_link", link_o, 0);
    chk("ar_br_cnt", br_cnt_o, 0);
    chk("ar_mp_cnt", mp_cnt_o, 0);
    chk("ar_br2", br2, 0);
    begin
      int nz;
      nz = 0;
      for (int i = 0; i < 64; i++) begin
        fetch_pc_i = 32'(i * 4);
        #1;
        if (fetch_pred_taken_o !== 1'b0) nz++;
      end
      chk("ar_table_all_wnt", nz, 0);
    end
    step();
    reset = 0;
    idle();
    step();

    // JAL wrap-around
    idle();
    valid_i = 1; Jump_i = 1; pc_i = 32'hFFFF_FFFC; imm_i = 32'h8;
    step();
    chk("jal_redirect", redirect_pc_o, 32'h4);
    chk("jal_link", link_o, 32'h0);
    chk("jal_pcsrc", PCSrc_o, 2'b01);
    chk("jal_mp", mispredict_o, 1);
    chk("jal_br_cnt", br_cnt_o, 0);
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Parametrised, registered branch resolution unit for the pipelined RV32I core.
- Resolves conditional branches, JAL and JALR in execute; computes the target and link address.
- Holds a bimodal table of 2-bit counters, read by fetch for direction prediction and trained by resolved branches.
- Flags mispredicts, outputs the redirect PC, and keeps saturating branch and mispredict counters.

Parameters:
- N, 32, operand and PC width.
- DEPTH, 64, predictor entries; power of two, at least 2.
- CNT_W, 16, width of the branch and mispredict counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- valid_i  in  1  execute slot holds a valid instruction.
- stall_i  in  1  hold the pipeline; input is not accepted.
- flush_i  in  1  discard the in-flight input and cancel the registered result.
- pc_i  in  N  PC of the instruction.
- a_i, b_i  in  N  rs1 and rs2 values.
- imm_i  in  N  sign-extended immediate.
- comp_ctrl_i  in  3  `COMP_* code from defs.sv.
- Branch_i, Jump_i, Jalr_i  in  1  decoded control.
- pred_taken_i  in  1  direction that fetch used for this instruction.
- fetch_pc_i  in  N  PC currently being fetched.
- fetch_pred_taken_o  out  1  MSB of the counter indexed by fetch_pc_i.
- res_valid_o  out  1  registered result valid.
- PCSrc_o  out  2  00 = PC+4, 01 = PC-relative target, 10 = JALR target.
- taken_o  out  1  resolved direction.
- mispredict_o  out  1  fetch must redirect.
- redirect_pc_o  out  N  correct next PC.
- link_o  out  N  pc_i + 4, for rd.
- br_cnt_o, mp_cnt_o  out  CNT_W  resolved-branch and mispredict counters.

Behaviour:
- Reset (async, any cycle):
  - All outputs go to 0.
  - Every counter entry goes to 2'b01 (weakly not-taken).
  - Perf counters go to 0.
  - Reset mid-operation drops any in-flight result; no table write occurs on the reset edge.
- Accept condition: acc = valid_i & ~stall_i & ~flush_i. All results appear registered, one cycle after acceptance.
- Compare rules:
  - eq/ne: full N-bit equality.
  - lt/ge: signed a_i versus signed b_i.
  - ltu/geu: unsigned.
  - Undefined comp_ctrl codes give cond = 0.
- Priority: Jump > Jalr > Branch.
  - Jump: taken = 1, target = pc_i + imm_i, PCSrc = 01.
  - Jalr: taken = 1, target = (a_i + imm_i) with bit 0 cleared, PCSrc = 10.
  - Branch: taken = cond, target = pc_i + imm_i, PCSrc = taken ? 01 : 00.
  - None of the three: taken = 0, PCSrc = 00.
- Adders are N-bit modulo; wrap-around past 2^N is silent.
- redirect_pc_o = taken ? target : link. link_o = pc_i + 4, also modulo.
- Mispredict:
  - Branch: mispredict = (taken != pred_taken_i).
  - Jump/Jalr: mispredict = 1 always; the table predicts direction only and has no target store.
  - Non-control instructions: mispredict = 0.
- Predictor index: pc[$clog2(DEPTH)+1:2].
  - The fetch read is combinational.
  - Update happens on the acceptance edge, for Branch only (not Jump or Jalr).
  - Taken increments and not-taken decrements, saturating at 00 and 11.
  - A same-cycle read of the index being written returns the old value; there is no bypass.
- Perf counters, both saturating at 2^CNT_W - 1:
  - br_cnt increments on each accepted Branch.
  - mp_cnt increments on each accepted instruction whose mispredict would be 1.
- Stall (stall_i = 1, flush_i = 0): all output registers hold, including res_valid_o. No table or counter update.
- Flush: res_valid_o = 0 next cycle; mispredict_o and PCSrc_o go to 0; no table or counter update. Flush beats stall.
- res_valid_o = 0 after a non-accepting, non-stall cycle. When res_valid_o = 0, mispredict_o = 0 and PCSrc_o = 00.

Decomposition:
- Shared package holds:
  - the comp_ctrl codes (migrate the `COMP_* defines as a typedef enum);
  - the PCSrc encoding (PCSRC_SEQ, PCSRC_REL, PCSRC_JALR);
  - the 2-bit counter constants (SNT, WNT, WT, ST).
- One sub-module: bimodal_pred.
  - Parameters: DEPTH, N.
  - Ports: read port, write port (update-enable, index, taken), async reset.
- Compare, target and mispredict logic stays in branch_unit.

Test Plan:
- Reset, then BLT with a = 0xFFFF_FFFF, b = 1, pc = 0x100, imm = 0x20, pred = 0 -> next cycle: taken = 1, PCSrc = 01, redirect = 0x120, mispredict = 1, mp_cnt = 1.
  - Same operands as BLTU, pred = 0 -> taken = 0, redirect = 0x104, mispredict = 0.
- JALR with a = 0x1003, imm = 0x4 -> redirect = 0x1006, PCSrc = 10, link = pc + 4, mispredict = 1; br_cnt unchanged.
- Counter training: fetch_pc = 0x40 initially -> pred = 0.
  - After one taken BEQ at pc 0x40 -> pred = 1.
  - After three more taken BEQs, then one not-taken -> pred still 1; the entry is 10.
  - An aliasing PC, 0x40 + 4·DEPTH, reads the same entry.
- Stall held 3 cycles after a result -> outputs stable, no counter change. Flush asserted together with stall and valid_i -> res_valid = 0 next cycle, table entry unchanged.
- Assert reset in the cycle after acceptance -> res_valid and all outputs 0 immediately; fetch_pred for every index = 0; counters 0.
- CNT_W = 2: 5 accepted branches -> br_cnt saturates at 3. pc = 0xFFFF_FFFC with JAL imm 8 -> redirect = 0x4, link = 0x0.
